cp0_unit: RTL and testbench

Parametrised MIPS32 coprocessor-0 register file and interrupt controller for the 5-stage pipeline. It holds BadVAddr, Count, Compare, Status, Cause, EPC, PRId and Config, and commits exception/ERET state updates from the memory stage. It runs a prescaled Count/Compare timer and produces the masked interrupt request consumed by the exception logic.

---
 rtl/cp0_unit.sv | 142 ++++++++++++++
 tb/tb_cp0_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// MIPS32 CP0 register file, Count/Compare timer and interrupt masking; reads are combinational,
// commits land at the clock edge, and ext_int is seen by int_req two cycles after it rises.
module cp0_unit #(
   parameter int          N_EXT_INT  = 6,
   parameter int          COUNT_DIV  = 2,
   parameter int          TIMER_IP   = 7,
   parameter logic [31:0] PRID_VAL   = 32'h00004220,
   parameter logic [31:0] CONFIG_VAL = 32'h80000000
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [N_EXT_INT-1:0] ext_int,
   input  logic [4:0]           rd_idx,
   output logic [31:0]          rd_val,
   input  logic                 wr_en,
   input  logic [4:0]           wr_idx,
   input  logic [31:0]          wr_data,
   input  logic                 exc_valid,
   input  logic [4:0]           exc_code,
   input  logic [31:0]          exc_pc,
   input  logic                 exc_bd,
   input  logic                 exc_bad_valid,
   input  logic [31:0]          exc_bad_addr,
   input  logic                 eret,
   output logic [31:0]          epc_out,
   output logic                 exl_out,
   output logic                 int_req
);

   localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

   localparam logic [4:0] IDX_BADVADDR = 5'd8;
   localparam logic [4:0] IDX_COUNT    = 5'd9;
   localparam logic [4:0] IDX_COMPARE  = 5'd11;
   localparam logic [4:0] IDX_STATUS   = 5'd12;
   localparam logic [4:0] IDX_CAUSE    = 5'd13;
   localparam logic [4:0] IDX_EPC      = 5'd14;
   localparam logic [4:0] IDX_PRID     = 5'd15;
   localparam logic [4:0] IDX_CONFIG   = 5'd16;

   logic [31:0]          badvaddr, count, compare, epc;
   logic [7:0]           im;
   logic                 exl, ie, bd, ti;
   logic [1:0]           ip_sw;
   logic [4:0]           exc_code_q;
   logic [PW-1:0]        presc;
   logic [N_EXT_INT-1:0] sync1, sync2;
   logic [7:0]           ip;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         badvaddr   <= '0;
         count      <= '0;
         compare    <= '0;
         epc        <= '0;
         im         <= '0;
         exl        <= 1'b0;
         ie         <= 1'b0;
         bd         <= 1'b0;
         ti         <= 1'b0;
         ip_sw      <= '0;
         exc_code_q <= '0;
         presc      <= '0;
         sync1      <= '0;
         sync2      <= '0;
      end else begin
         sync1 <= ext_int;
         sync2 <= sync1;

         if (presc == PRESC_MAX) begin
            presc <= '0;
            count <= count + 32'd1;
         end else begin
            presc <= presc + 1'b1;
         end
         if (count == compare && compare != 32'd0)
            ti <= 1'b1;

         // Later assignments below override the free-running timer updates above.
         if (exc_valid) begin
            exc_code_q <= exc_code;
            if (exc_bad_valid)
               badvaddr <= exc_bad_addr;
            if (!exl) begin
               epc <= exc_bd ? exc_pc - 32'd4 : exc_pc;
               bd  <= exc_bd;
               exl <= 1'b1;
            end
         end else if (eret) begin
            exl <= 1'b0;
         end else if (wr_en) begin
            case (wr_idx)
               IDX_COUNT: begin
                  count <= wr_data;
                  presc <= '0;
               end
               IDX_COMPARE: begin
                  compare <= wr_data;
                  ti      <= 1'b0;
               end
               IDX_STATUS: begin
                  im  <= wr_data[15:8];
                  exl <= wr_data[1];
                  ie  <= wr_data[0];
               end
               IDX_CAUSE: ip_sw <= wr_data[9:8];
               IDX_EPC:   epc   <= wr_data;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      ip = '0;
      ip[1:0] = ip_sw;
      for (int i = 0; i < N_EXT_INT; i++)
         ip[2+i] = sync2[i];
      ip[TIMER_IP] = ip[TIMER_IP] | ti;
   end

   always_comb begin
      rd_val = '0;
      case (rd_idx)
         IDX_BADVADDR: rd_val = badvaddr;
         IDX_COUNT:    rd_val = count;
         IDX_COMPARE:  rd_val = compare;
         IDX_STATUS:   rd_val = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
         IDX_CAUSE:    rd_val = {bd, ti, 14'b0, ip, 1'b0, exc_code_q, 2'b0};
         IDX_EPC:      rd_val = epc;
         IDX_PRID:     rd_val = PRID_VAL;
         IDX_CONFIG:   rd_val = CONFIG_VAL;
         default:      rd_val = '0;
      endcase
   end

   assign epc_out = epc;
   assign exl_out = exl;
   assign int_req = (|(ip & im)) & ie & ~exl;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: a default instance plus an N_EXT_INT=2 instance sharing all commit inputs.
module tb_cp0_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic [5:0]  ext_int;
   logic [1:0]  ext_int2;
   logic [4:0]  rd_idx;
   logic [31:0] rd_val, rd_val2;
   logic        wr_en;
   logic [4:0]  wr_idx;
   logic [31:0] wr_data;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic [31:0] exc_pc;
   logic        exc_bd;
   logic        exc_bad_valid;
   logic [31:0] exc_bad_addr;
   logic        eret;
   logic [31:0] epc_out, epc_out2;
   logic        exl_out, exl_out2;
   logic        int_req, int_req2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cp0_unit u_dut (
      .clk(clk), .resetn(resetn), .ext_int(ext_int), .rd_idx(rd_idx), .rd_val(rd_val),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .exc_valid(exc_valid),
      .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd), .exc_bad_valid(exc_bad_valid),
      .exc_bad_addr(exc_bad_addr), .eret(eret), .epc_out(epc_out), .exl_out(exl_out),
      .int_req(int_req)
   );

   cp0_unit #(.N_EXT_INT(2)) u_dut2 (
      .clk(clk), .resetn(resetn), .ext_int(ext_int2), .rd_idx(rd_idx), .rd_val(rd_val2),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .exc_valid(exc_valid),
      .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd), .exc_bad_valid(exc_bad_valid),
      .exc_bad_addr(exc_bad_addr), .eret(eret), .epc_out(epc_out2), .exl_out(exl_out2),
      .int_req(int_req2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] idx, input logic [31:0] data);
      wr_en = 1'b1; wr_idx = idx; wr_data = data;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [4:0] idx, output logic [31:0] val);
      rd_idx = idx;
      #1;
      val = rd_val;
   endtask

   task automatic raise_exc(input logic [4:0] code, input logic [31:0] pc, input logic bdv,
                            input logic badv, input logic [31:0] bad);
      exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_bd = bdv;
      exc_bad_valid = badv; exc_bad_addr = bad;
      tick();
      exc_valid = 1'b0; exc_bad_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      resetn = 1'b0; ext_int = '0; ext_int2 = '0; rd_idx = '0; wr_en = 1'b0; wr_idx = '0;
      wr_data = '0; exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
      exc_bad_valid = 1'b0; exc_bad_addr = '0; eret = 1'b0;
      tick(); tick();
      resetn = 1'b1;
      rd(5'd12, v); checks++;
      if (v !== 32'h00400000) begin failures++; $display("FAIL reset_status got=%h exp=%h", v, 32'h00400000); end
      rd(5'd13, v); checks++;
      if (v !== 32'h0) begin failures++; $display("FAIL reset_cause got=%h exp=0", v); end
      rd(5'd15, v); checks++;
      if (v !== 32'h00004220) begin failures++; $display("FAIL reset_prid got=%h exp=00004220", v); end
      rd(5'd16, v); checks++;
      if (v !== 32'h80000000) begin failures++; $display("FAIL reset_config got=%h exp=80000000", v); end
      rd(5'd9, v); checks++;
      if (v !== 32'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", v); end
      checks++;
      if ({int_req, exl_out, epc_out} !== 34'h0) begin
         failures++; $display("FAIL reset_outputs int_req=%b exl=%b epc=%h exp 0/0/0", int_req, exl_out, epc_out);
      end
   endtask

   task automatic test_timer();
      logic [31:0] v;
      bit found = 0;
      mtc0(5'd9, 32'hFFFFFFFE);
      repeat (4) tick();
      rd(5'd9, v); checks++;
      if (v !== 32'h0) begin failures++; $display("FAIL count_wrap got=%h exp=0", v); end
      mtc0(5'd11, 32'd5);
      for (int i = 0; i < 40; i++) begin
         rd(5'd9, v);
         if (v == 32'd5) begin found = 1; break; end
         tick();
      end
      checks++;
      if (!found) begin failures++; $display("FAIL count_reach5 timeout count=%h exp=5", v); end
      rd(5'd13, v); checks++;
      if (v[30] !== 1'b0) begin failures++; $display("FAIL ti_at_match got=%b exp=0", v[30]); end
      tick();
      rd(5'd13, v); checks++;
      if ({v[30], v[15]} !== 2'b11) begin failures++; $display("FAIL ti_set ti=%b ip7=%b exp 1/1", v[30], v[15]); end
      mtc0(5'd12, 32'h8001);
      checks++;
      if (int_req !== 1'b1) begin failures++; $display("FAIL timer_int_req got=%b exp=1", int_req); end
      mtc0(5'd11, 32'h100);
      rd(5'd13, v); checks++;
      if ({v[30], v[15]} !== 2'b00) begin failures++; $display("FAIL ti_clear ti=%b ip7=%b exp 0/0", v[30], v[15]); end
      checks++;
      if (int_req !== 1'b0) begin failures++; $display("FAIL ti_clear_int_req got=%b exp=0", int_req); end
   endtask

   task automatic test_exception();
      logic [31:0] v;
      raise_exc(5'd4, 32'hBFC00104, 1'b1, 1'b1, 32'h13);
      checks++;
      if (epc_out !== 32'hBFC00100) begin failures++; $display("FAIL exc_epc got=%h exp=bfc00100", epc_out); end
      checks++;
      if (exl_out !== 1'b1) begin failures++; $display("FAIL exc_exl got=%b exp=1", exl_out); end
      rd(5'd8, v); checks++;
      if (v !== 32'h13) begin failures++; $display("FAIL exc_badvaddr got=%h exp=13", v); end
      rd(5'd13, v); checks++;
      if ((v & 32'h8000007C) !== 32'h80000010) begin failures++; $display("FAIL exc_cause got=%h exp_masked=80000010", v & 32'h8000007C); end
      checks++;
      if (int_req !== 1'b0) begin failures++; $display("FAIL exc_int_req got=%b exp=0", int_req); end
      raise_exc(5'd8, 32'h200, 1'b0, 1'b0, 32'hDEAD);
      checks++;
      if (epc_out !== 32'hBFC00100) begin failures++; $display("FAIL nested_epc got=%h exp=bfc00100", epc_out); end
      rd(5'd13, v); checks++;
      if ((v & 32'h8000007C) !== 32'h80000020) begin failures++; $display("FAIL nested_cause got=%h exp_masked=80000020", v & 32'h8000007C); end
      rd(5'd8, v); checks++;
      if (v !== 32'h13) begin failures++; $display("FAIL nested_badvaddr got=%h exp=13", v); end
      eret = 1'b1; tick(); eret = 1'b0;
      checks++;
      if (exl_out !== 1'b0 || epc_out !== 32'hBFC00100) begin
         failures++; $display("FAIL eret exl=%b epc=%h exp 0/bfc00100", exl_out, epc_out);
      end
   endtask

   task automatic test_priority();
      logic [31:0] v;
      wr_en = 1'b1; wr_idx = 5'd12; wr_data = 32'h0; eret = 1'b1;
      raise_exc(5'd12, 32'h300, 1'b0, 1'b0, 32'h0);
      wr_en = 1'b0; eret = 1'b0;
      rd(5'd12, v); checks++;
      if (v !== 32'h00408003) begin failures++; $display("FAIL prio_status got=%h exp=00408003", v); end
      checks++;
      if (epc_out !== 32'h300) begin failures++; $display("FAIL prio_epc got=%h exp=300", epc_out); end
      rd(5'd13, v); checks++;
      if ((v & 32'h8000007C) !== 32'h00000030) begin failures++; $display("FAIL prio_cause got=%h exp_masked=30", v & 32'h8000007C); end
      eret = 1'b1; tick(); eret = 1'b0;
      mtc0(5'd11, 32'd100);
      mtc0(5'd9, 32'd100);
      mtc0(5'd11, 32'd100);
      rd(5'd13, v); checks++;
      if (v[30] !== 1'b0) begin failures++; $display("FAIL cmp_write_vs_match ti=%b exp=0", v[30]); end
      tick();
      rd(5'd13, v); checks++;
      if (v[30] !== 1'b1) begin failures++; $display("FAIL match_after_write ti=%b exp=1", v[30]); end
      mtc0(5'd11, 32'd0);
      rd(5'd13, v); checks++;
      if (v[30] !== 1'b0) begin failures++; $display("FAIL ti_clear2 ti=%b exp=0", v[30]); end
   endtask

   task automatic test_ext_int();
      logic [31:0] v;
      mtc0(5'd12, 32'h0401);
      ext_int = 6'b000001;
      #1; checks++;
      if (int_req !== 1'b0) begin failures++; $display("FAIL ext_sync0 got=%b exp=0", int_req); end
      tick(); checks++;
      if (int_req !== 1'b0) begin failures++; $display("FAIL ext_sync1 got=%b exp=0", int_req); end
      tick(); checks++;
      if (int_req !== 1'b1) begin failures++; $display("FAIL ext_sync2 got=%b exp=1", int_req); end
      rd(5'd13, v); checks++;
      if (v[15:10] !== 6'b000001) begin failures++; $display("FAIL ext_ip got=%b exp=000001", v[15:10]); end
      ext_int = '0;
      mtc0(5'd12, 32'h0801);
      ext_int2 = 2'b10;
      tick(); checks++;
      if (int_req2 !== 1'b0) begin failures++; $display("FAIL ext2_sync1 got=%b exp=0", int_req2); end
      tick(); checks++;
      if (int_req2 !== 1'b1) begin failures++; $display("FAIL ext2_sync2 got=%b exp=1", int_req2); end
      rd_idx = 5'd13; #1; checks++;
      if (rd_val2[15:10] !== 6'b000010) begin failures++; $display("FAIL ext2_ip got=%b exp=000010", rd_val2[15:10]); end
      checks++;
      if (int_req !== 1'b0) begin failures++; $display("FAIL ext2_dut1_quiet got=%b exp=0", int_req); end
      ext_int2 = '0;
   endtask

   initial begin
      test_reset();
      test_timer();
      test_exception();
      test_priority();
      test_ext_int();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
